// File: rtl/i2s_rx_ctrl_if.sv
// Sample stream from the I2S receive controller to the FFT sample buffer.
// The controller drives the master modport and the buffer drives the slave modport.
interface i2s_rx_ctrl_if #(
  parameter int unsigned SAMPLE_WIDTH = 24
) ();
  logic [SAMPLE_WIDTH-1:0] sample_data;
  logic                    sample_chan;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    sample_last;

  modport master (
    output sample_data,
    output sample_chan,
    output sample_valid,
    output sample_last,
    input  sample_ready
  );

  modport slave (
    input  sample_data,
    input  sample_chan,
    input  sample_valid,
    input  sample_last,
    output sample_ready
  );
endinterface

// File: rtl/i2s_rx_ctrl.sv
// I2S receive controller: gates the clock generator, skips warm-up frames and streams one
// capture window of SD samples. Define I2S_RX_STEREO_EN to capture both slots.
module i2s_rx_ctrl #(
  parameter int unsigned SAMPLE_WIDTH  = 24,
  parameter int unsigned WINDOW_LEN    = 256,
  parameter int unsigned WARMUP_FRAMES = 4,
  parameter bit          CHANNEL       = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          bclk,
  input  logic          lrclk,
  input  logic          sd,
  input  logic          start,
  output logic          clkgen_rst_n,
  output logic          busy,
  i2s_rx_ctrl_if.master smp,
  output logic          overrun,
  output logic          done
);

  localparam int unsigned FcW = $clog2(WARMUP_FRAMES + 1) + 1;
  localparam int unsigned WcW = $clog2(WINDOW_LEN + 1);

  typedef enum logic [2:0] {StIdle, StSync, StWarmup, StCapture, StDrain} state_e;

  state_e                  state_q, state_d;
  logic                    bclk_q;
  logic                    lr_q, lr_d;
  logic [4:0]              p_q, p_d;
  logic [SAMPLE_WIDTH-1:0] shreg_q, shreg_d;
  logic [FcW-1:0]          frame_q, frame_d;
  logic [WcW-1:0]          win_q, win_d;
  logic [SAMPLE_WIDTH-1:0] data_q, data_d;
  logic                    chan_q, chan_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;
  logic                    overrun_q, overrun_d;
  logic                    done_q, done_d;
`ifdef I2S_RX_STEREO_EN
  logic                    left_seen_q, left_seen_d;
`endif

  logic                    rise, left_start, word_done;
  logic [SAMPLE_WIDTH-1:0] shifted;
  logic                    slot_ok, last_cand, count_inc;
  logic                    accept, capture_hit, hs, load, drop;

  // Slot tracking and deserialisation
  always_comb begin
    rise       = bclk & ~bclk_q;
    left_start = rise & (lrclk != lr_q) & ~lrclk;
    // The sd bit arriving on the completing rise is the word's LSB.
    shifted    = (shreg_q << 1) | SAMPLE_WIDTH'(sd);
    word_done  = rise & (lrclk == lr_q) & (p_q == 5'(SAMPLE_WIDTH - 1));

    lr_d    = lr_q;
    p_d     = p_q;
    shreg_d = shreg_q;
    if (rise) begin
      lr_d = lrclk;
      if (lrclk != lr_q) begin
        p_d     = 5'd0;
        shreg_d = '0;
      end else begin
        if (p_q != 5'd31) p_d = p_q + 5'd1;
        if (p_q < 5'(SAMPLE_WIDTH)) shreg_d = shifted;
      end
    end
  end

  // Slot selection and window bookkeeping
  always_comb begin
`ifdef I2S_RX_STEREO_EN
    // Emission always opens with a left sample; the window counts frames.
    slot_ok   = ~lrclk | left_seen_q;
    count_inc = lrclk;
    last_cand = lrclk & (win_q == WcW'(WINDOW_LEN - 1));
`else
    slot_ok   = (lrclk == CHANNEL);
    count_inc = 1'b1;
    last_cand = (win_q == WcW'(WINDOW_LEN - 1));
`endif
    accept      = (state_q == StIdle) & start;
    capture_hit = (state_q == StCapture) & word_done & slot_ok;
    hs          = valid_q & smp.sample_ready;
    load        = capture_hit & (~valid_q | hs);
    drop        = capture_hit & valid_q & ~smp.sample_ready;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (start) state_d = StSync;
      StSync:    if (left_start) state_d = (WARMUP_FRAMES == 0) ? StCapture : StWarmup;
      StWarmup:  if (left_start && (frame_q + FcW'(1) == FcW'(WARMUP_FRAMES))) state_d = StCapture;
      StCapture: if (load && last_cand) state_d = StDrain;
      StDrain:   if (hs && last_q) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy         = 1'b0;
    clkgen_rst_n = 1'b0;
    if (state_q != StIdle) begin
      busy         = 1'b1;
      clkgen_rst_n = 1'b1;
    end
  end

  // Counters and output stream registers
  always_comb begin
    frame_d   = frame_q;
    win_d     = win_q;
    data_d    = data_q;
    chan_d    = chan_q;
    valid_d   = valid_q;
    last_d    = last_q;
    overrun_d = overrun_q;
    done_d    = (state_q == StDrain) & hs & last_q;
`ifdef I2S_RX_STEREO_EN
    left_seen_d = left_seen_q;
`endif
    if (accept) begin
      frame_d   = '0;
      win_d     = '0;
      last_d    = 1'b0;
      overrun_d = 1'b0;
`ifdef I2S_RX_STEREO_EN
      left_seen_d = 1'b0;
`endif
    end
    if ((state_q == StWarmup) && left_start) frame_d = frame_q + FcW'(1);
    if (hs) valid_d = 1'b0;
    if (load) begin
      valid_d = 1'b1;
      data_d  = shifted;
      chan_d  = lrclk;
      last_d  = last_cand;
      if (count_inc) win_d = win_q + WcW'(1);
`ifdef I2S_RX_STEREO_EN
      if (!lrclk) left_seen_d = 1'b1;
`endif
    end
    if (drop) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      bclk_q    <= 1'b0;
      lr_q      <= 1'b0;
      p_q       <= 5'd0;
      shreg_q   <= '0;
      frame_q   <= '0;
      win_q     <= '0;
      data_q    <= '0;
      chan_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef I2S_RX_STEREO_EN
      left_seen_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      bclk_q    <= bclk;
      lr_q      <= lr_d;
      p_q       <= p_d;
      shreg_q   <= shreg_d;
      frame_q   <= frame_d;
      win_q     <= win_d;
      data_q    <= data_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
`ifdef I2S_RX_STEREO_EN
      left_seen_q <= left_seen_d;
`endif
    end
  end

  assign smp.sample_data  = data_q;
  assign smp.sample_chan  = chan_q;
  assign smp.sample_valid = valid_q;
  assign smp.sample_last  = last_q;
  assign overrun          = overrun_q;
  assign done             = done_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: drives I2S frames, scoreboards the emitted sample stream and
// checks reset, done/busy timing, backpressure, alignment and mid-window reset.
module tb_i2s_rx_ctrl;

  localparam int unsigned W    = 24;
  localparam int unsigned WARM = 2;
`ifdef I2S_RX_STEREO_EN
  localparam int unsigned WIN  = 2;
`else
  localparam int unsigned WIN  = 4;
`endif

  logic clk = 1'b0;
  logic rst, bclk, lrclk, sd, start;
  logic clkgen_rst_n, busy, overrun, done;

  i2s_rx_ctrl_if #(.SAMPLE_WIDTH(W)) smp_if ();

  i2s_rx_ctrl #(
    .SAMPLE_WIDTH (W),
    .WINDOW_LEN   (WIN),
    .WARMUP_FRAMES(WARM),
    .CHANNEL      (1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sd          (sd),
    .start       (start),
    .clkgen_rst_n(clkgen_rst_n),
    .busy        (busy),
    .smp         (smp_if),
    .overrun     (overrun),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -10;
  int last_hs_cyc = -20;
  bit lr_seen = 1'b0;
  logic [25:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every handshake pops the oldest expected {last, chan, data}.
  always @(negedge clk) begin
    if (!rst && smp_if.sample_valid && smp_if.sample_ready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL sample_unexpected: observed 0x%0h required none",
               {smp_if.sample_last, smp_if.sample_chan, smp_if.sample_data});
      end
      if (exp_q.size() != 0)
        chk("sample", 32'({smp_if.sample_last, smp_if.sample_chan, smp_if.sample_data}),
            32'(exp_q.pop_front()));
      if (smp_if.sample_last) last_hs_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed no end of run required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_bit(input logic lr, input logic b);
    bclk = 1'b0;
    lrclk = lr;
    sd = b;
    lr_seen = lr;
    repeat (2) @(posedge clk);
    #1 bclk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic drive_slot(input logic lr, input logic [23:0] word, input logic b0,
                            input bit push, input bit last);
    if (push) exp_q.push_back({last, lr, word});
    drive_bit(lr, b0);
    for (int i = 23; i >= 0; i--) drive_bit(lr, word[i]);
    for (int i = 0; i < 7; i++) drive_bit(lr, 1'($urandom));
  endtask

  task automatic mono_frame(input logic [23:0] word, input logic b0, input bit push,
                            input bit last);
    drive_slot(1'b0, word, b0, push, last);
    drive_slot(1'b1, 24'($urandom), 1'($urandom), 1'b0, 1'b0);
  endtask

  // Frames discarded before capture: warm-up frames plus one more if the first
  // left slot after start carries no LRCLK edge.
  task automatic junk_frames();
    int n;
    n = WARM + (lr_seen ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      drive_slot(1'b0, 24'($urandom), 1'($urandom), 1'b0, 1'b0);
      drive_slot(1'b1, 24'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    chk("busy_before_start", 32'(busy), 32'd0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("clkgen_after_start", 32'(clkgen_rst_n), 32'd1);
    chk("overrun_cleared", 32'(overrun), 32'd0);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 2000 && done_cnt == 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("done_count", 32'(done_cnt), 32'd1);
    chk("done_timing", 32'(done_cyc), 32'(last_hs_cyc + 1));
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("clkgen_after_done", 32'(clkgen_rst_n), 32'd0);
    chk("valid_after_done", 32'(smp_if.sample_valid), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    bclk = 1'b0;
    lrclk = 1'b0;
    done_cnt = 0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(smp_if.sample_data), 32'd0);
    chk({tag, "_chan"}, 32'(smp_if.sample_chan), 32'd0);
    chk({tag, "_valid"}, 32'(smp_if.sample_valid), 32'd0);
    chk({tag, "_last"}, 32'(smp_if.sample_last), 32'd0);
    chk({tag, "_overrun"}, 32'(overrun), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_clkgen"}, 32'(clkgen_rst_n), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b1;
    bclk = 1'b0;
    lrclk = 1'b0;
    sd = 1'b0;
    smp_if.sample_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    reset_outputs("reset");

`ifdef I2S_RX_STEREO_EN
    do_start();
    junk_frames();
    drive_slot(1'b0, 24'h111111, 1'($urandom), 1'b1, 1'b0);
    drive_slot(1'b1, 24'h222222, 1'($urandom), 1'b1, 1'b0);
    drive_slot(1'b0, 24'h333333, 1'($urandom), 1'b1, 1'b0);
    drive_slot(1'b1, 24'h444444, 1'($urandom), 1'b1, 1'b1);
    wait_done();
`else
    // Basic window; a start pulse mid-window must be ignored.
    do_start();
    junk_frames();
    mono_frame(24'h800001, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'h7FFFFF, 1'($urandom), 1'b1, 1'b0);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_ignores_start", 32'(busy), 32'd1);
    mono_frame(24'h000000, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'hA5A5A5, 1'($urandom), 1'b1, 1'b1);
    wait_done();
    chk("overrun_clean_run", 32'(overrun), 32'd0);

    // Alignment (sd=1 on the p=0 bit) plus backpressure causing one dropped sample.
    do_start();
    junk_frames();
    smp_if.sample_ready = 1'b0;
    mono_frame(24'h000001, 1'b1, 1'b1, 1'b0);
    mono_frame(24'hC3C3C3, 1'($urandom), 1'b0, 1'b0);
    chk("held_data", 32'(smp_if.sample_data), 32'h000001);
    chk("held_valid", 32'(smp_if.sample_valid), 32'd1);
    chk("overrun_set", 32'(overrun), 32'd1);
    smp_if.sample_ready = 1'b1;
    mono_frame(24'h123456, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'hFEDCBA, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'h0F0F0F, 1'($urandom), 1'b1, 1'b1);
    wait_done();
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Asynchronous reset in the middle of capture with a sample pending.
    do_start();
    junk_frames();
    smp_if.sample_ready = 1'b0;
    drive_slot(1'b0, 24'h5A5A5A, 1'($urandom), 1'b0, 1'b0);
    chk("pending_valid", 32'(smp_if.sample_valid), 32'd1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    reset_outputs("async_rst");
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bclk = 1'b0;
    lrclk = 1'b0;
    lr_seen = 1'b0;
    done_cnt = 0;
    smp_if.sample_ready = 1'b1;

    // Fresh full window after the reset.
    do_start();
    junk_frames();
    mono_frame(24'h13579B, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'h2468AC, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'hFFFFFF, 1'($urandom), 1'b1, 1'b0);
    mono_frame(24'h000002, 1'($urandom), 1'b1, 1'b1);
    wait_done();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_rx_ctrl.md
# i2s_rx_ctrl

I2S receive controller for the microphone front end. It gates the I2S clock generator through a reset output, discards start-up frames while the microphone settles, deserialises the mic's SD line on BCLK rising edges, and delivers one capture window of samples to the FFT buffer over a valid/ready stream. It sits between the I2S clock generator and pad inputs on one side and the FFT sample buffer on the other.

## Interface
- SAMPLE_WIDTH, 24, bits captured per slot (MSB-first), 1..31
- WINDOW_LEN, 256, samples (or stereo frames) per capture window, ≥1
- WARMUP_FRAMES, 4, complete frames discarded after the clock starts, ≥0
- CHANNEL, 0, mono slot captured: 0 = left (LRCLK low), 1 = right
- clk  in  1  system clock (also clocks the I2S clock generator)
- rst  in  1  asynchronous, active-high reset
- bclk  in  1  BCLK level from the clock generator, synchronous to clk
- lrclk  in  1  LRCLK level from the clock generator, synchronous to clk
- sd  in  1  mic serial data, already synchronised to clk
- start  in  1  one-cycle request to capture one window
- clkgen_rst_n  out  1  active-low reset to the clock generator; low stops BCLK/LRCLK
- busy  out  1  high from accepted start until done
- sample_data  out  SAMPLE_WIDTH  captured sample, raw two's complement
- sample_chan  out  1  slot of sample_data (0 = left)
- sample_valid  out  1  sample_data holds an unconsumed sample
- sample_ready  in  1  downstream accepts when valid && ready
- sample_last  out  1  qualifies the final sample of the window
- overrun  out  1  sticky: a sample was dropped; cleared on accepted start
- done  out  1  one-cycle pulse after the last sample is accepted

## Operation
- Edge detect: bclk_q is a registered copy of bclk. rise = bclk & ~bclk_q. All slot logic advances only on rise cycles.
- Slot tracking: lr_q holds lrclk sampled at the previous rise. On a rise with lrclk != lr_q: p <= 0, shift register cleared. Otherwise p <= p+1, saturating at 31.
- When 1 ≤ p ≤ SAMPLE_WIDTH, sd shifts into the LSB, so the MSB arrives first. The p=0 bit (the previous word's LSB) is ignored.
- On the rise where p reaches SAMPLE_WIDTH, the sample for slot lrclk is complete.
- A left-slot start is a rise with lrclk=0 and lr_q=1. Frames are counted at left-slot starts.
- FSM:
  - IDLE: clkgen_rst_n=0, busy=0. On start → SYNC, and overrun is cleared.
  - SYNC: clkgen_rst_n=1. At the first left-slot start → WARMUP (frame count 0), or directly → CAPTURE if WARMUP_FRAMES=0.
  - WARMUP: increment at each left-slot start. At count == WARMUP_FRAMES → CAPTURE. No samples are emitted.
  - CAPTURE: emit completed samples of the selected slot(s). The window counter counts emitted samples. The sample that makes the count WINDOW_LEN carries sample_last. Once it is emitted → DRAIN.
  - DRAIN: wait for the last handshake, pulse done, → IDLE.
- Emission:
  - If sample_valid=0, or a handshake happens in the same cycle, the new sample loads and valid stays or goes high.
  - If sample_valid=1 and sample_ready=0 when a new sample completes, the new sample is dropped, overrun is set, and the window counter does not advance.
- start is ignored while busy=1.
- Before the first left-slot start in SYNC, partial slot data is never emitted.

## Timing
- Reset values: clkgen_rst_n=0, busy=0, sample_data=0, sample_chan=0, sample_valid=0, sample_last=0, overrun=0, done=0, FSM=IDLE, all counters 0.
- start accepted at cycle S → busy=1 and clkgen_rst_n=1 at S+1.
- Sample latency: rise with p=SAMPLE_WIDTH seen at cycle E → sample_valid, sample_data, sample_chan and sample_last are registered and visible at E+1.
- sample_valid holds until the handshake cycle and drops the cycle after, unless it is reloaded in the same cycle.
- done is high for exactly one cycle, the cycle after the last handshake. busy falls with done. clkgen_rst_n falls in the same cycle.
- rst mid-window: all outputs return to reset values immediately. The pending sample is lost and the clock generator is held in reset.

## Configuration
- I2S_RX_STEREO_EN defined:
  - Both slots are captured and emitted in order left then right.
  - WINDOW_LEN counts frames, so 2×WINDOW_LEN samples are emitted.
  - sample_last is on the right sample of the final frame.
  - CHANNEL is ignored.
  - In CAPTURE, emission begins with a left sample. A right sample completing before the first emitted left sample is discarded.
- Undefined: only slot CHANNEL is emitted, and sample_chan is constant CHANNEL.

## Test plan
- Mono, SAMPLE_WIDTH=24, WARMUP_FRAMES=2, WINDOW_LEN=4, left words 0x800001,0x7FFFFF,0x000000,0xA5A5A5 after 2 warm-up frames, ready=1 → exactly those 4 samples, chan=0, last only on 0xA5A5A5, done pulse one cycle later, clkgen_rst_n=0 after done.
- Alignment: LRCLK edge with sd=1 on the p=0 bit and word 0x000001 → sample_data=0x000001; the extra bit is not captured.
- Backpressure: ready=0 for 2 full slots while valid → first sample held unchanged, overrun=1, window still completes with WINDOW_LEN emitted samples.
- start pulsed while busy, and start at reset → no effect; overrun cleared only by the next accepted start.
- rst asserted mid-CAPTURE with valid=1 → all outputs reach reset values asynchronously; a later start captures a fresh full window.
- I2S_RX_STEREO_EN, WINDOW_LEN=2, L/R words 0x111111/0x222222, 0x333333/0x444444 → four samples in L,R,L,R order with chan 0,1,0,1, last on 0x444444.
